// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect encodings,
// default reset/bubble words and the fetch state enum.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ     = 2'b00;
    localparam logic [1:0] PCSRC_SEQ_ALT = 2'b01;
    localparam logic [1:0] PCSRC_BR      = 2'b10;
    localparam logic [1:0] PCSRC_J       = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        KILL  = 2'd2
    } if_state_t;

endpackage

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register with hold and bubble controls; bubble wins over hold.
module pipe_ifid_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] inst_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            inst_q  <= inst_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC, runs the valid/ready fetch to
// instruction memory and applies branch/jump redirects and load-use stalls.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Pcsrc,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] Jump_addr,
    input  logic        stall,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ready,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] D_Inst,
    output logic [31:0] D_PC4,
    output logic        D_Valid,
    output logic        Flush
);

    import pipe_pkg::*;

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] skid_q, skid_d;
    logic        flush_q, flush_d;

    logic        br, jmp, done;
    logic [31:0] pc_plus4;
    logic        ifid_hold, ifid_bubble;
    logic [31:0] ifid_inst;

    always_comb begin
        br  = 1'b0;
        jmp = 1'b0;
        unique case (Pcsrc)
            PCSRC_SEQ, PCSRC_SEQ_ALT: ;
            PCSRC_BR:                 br  = 1'b1;
            PCSRC_J:                  jmp = 1'b1;
        endcase
    end

    // Reset abandons any outstanding fetch, so the request drops while Rst is high.
    assign Imem_req  = !Rst && (state_q != HELD);
    assign Imem_addr = pc_q;
    assign done      = Imem_req && Imem_ready;
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        skid_d      = skid_q;
        flush_d     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_inst   = Imem_rdata;

        unique case (state_q)
            FETCH: begin
                if (br) begin
                    // The older branch kills the fetch even under a stall.
                    flush_d     = 1'b1;
                    ifid_bubble = 1'b1;
                    skid_d      = NOP_INST;
                    if (done) begin
                        pc_d = Branch_addr;
                    end else begin
                        redir_d = Branch_addr;
                        state_d = KILL;
                    end
                end else if (stall) begin
                    ifid_hold = 1'b1;
                    if (done) begin
                        skid_d  = Imem_rdata;
                        state_d = HELD;
                    end
                end else if (jmp) begin
                    ifid_bubble = 1'b1;
                    if (done) begin
                        pc_d = Jump_addr;
                    end else begin
                        redir_d = Jump_addr;
                        state_d = KILL;
                    end
                end else if (done) begin
                    pc_d = pc_plus4;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            HELD: begin
                if (br) begin
                    flush_d     = 1'b1;
                    ifid_bubble = 1'b1;
                    skid_d      = NOP_INST;
                    pc_d        = Branch_addr;
                    state_d     = FETCH;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (jmp) begin
                    ifid_bubble = 1'b1;
                    skid_d      = NOP_INST;
                    pc_d        = Jump_addr;
                    state_d     = FETCH;
                end else begin
                    ifid_inst = skid_q;
                    pc_d      = pc_plus4;
                    state_d   = FETCH;
                end
            end
            KILL: begin
                // Old address stays on the bus until its data is returned and dropped.
                ifid_bubble = 1'b1;
                if (br) begin
                    flush_d = 1'b1;
                    redir_d = Branch_addr;
                    if (done) begin
                        pc_d    = Branch_addr;
                        state_d = FETCH;
                    end
                end else if (done) begin
                    pc_d    = redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            redir_q <= RESET_PC;
            skid_q  <= NOP_INST;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            skid_q  <= skid_d;
            flush_q <= flush_d;
        end
    end

    pipe_ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .hold_i   (ifid_hold),
        .bubble_i (ifid_bubble),
        .inst_i   (ifid_inst),
        .pc4_i    (pc_plus4),
        .inst_o   (D_Inst),
        .pc4_o    (D_PC4),
        .valid_o  (D_Valid)
    );

    assign PC    = pc_q;
    assign Flush = flush_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage; memory returns word == address.
module tb_pipe_if_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  Pcsrc;
    logic [31:0] Branch_addr;
    logic [31:0] Jump_addr;
    logic        stall;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic [31:0] Imem_rdata;
    logic [31:0] PC;
    logic [31:0] D_Inst;
    logic [31:0] D_PC4;
    logic        D_Valid;
    logic        Flush;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign Imem_rdata = Imem_addr;

    pipe_if_stage dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Pcsrc       (Pcsrc),
        .Branch_addr (Branch_addr),
        .Jump_addr   (Jump_addr),
        .stall       (stall),
        .Imem_req    (Imem_req),
        .Imem_addr   (Imem_addr),
        .Imem_ready  (Imem_ready),
        .Imem_rdata  (Imem_rdata),
        .PC          (PC),
        .D_Inst      (D_Inst),
        .D_PC4       (D_PC4),
        .D_Valid     (D_Valid),
        .Flush       (Flush)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Pcsrc = 2'b00; stall = 1'b0; Imem_ready = 1'b1;
        Branch_addr = 32'h0; Jump_addr = 32'h0;
        step();
        Rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Pcsrc = 2'b00; stall = 1'b0; Imem_ready = 1'b1;
        Branch_addr = 32'h0; Jump_addr = 32'h0;
        #1;
        checks++;
        if (Imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req_low actual=%b expected=0", Imem_req);
        end
        step();
        checks++;
        if (PC !== 32'h0 || D_Valid !== 1'b0 || D_Inst !== 32'h0 || D_PC4 !== 32'h0
            || Flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_state actual pc=%h v=%b inst=%h pc4=%h fl=%b expected 0/0/0/0/0",
                     PC, D_Valid, D_Inst, D_PC4, Flush);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if (Imem_req !== 1'b1 || Imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req actual req=%b addr=%h expected 1/0", Imem_req, Imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (Imem_addr !== 32'(4 * i) || D_Inst !== 32'(4 * (i - 1)) || D_PC4 !== 32'(4 * i)
                || D_Valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_%0d actual addr=%h inst=%h pc4=%h v=%b expected %h/%h/%h/1",
                         i, Imem_addr, D_Inst, D_PC4, D_Valid, 4 * i, 4 * (i - 1), 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (PC !== 32'h8 || D_Inst !== 32'h4 || D_Valid !== 1'b1 || Imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d actual pc=%h inst=%h v=%b req=%b expected 8/4/1/0",
                         i, PC, D_Inst, D_Valid, Imem_req);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (D_Inst !== 32'h8 || D_PC4 !== 32'hC || D_Valid !== 1'b1 || PC !== 32'hC) begin
            errors++;
            $display("FAIL stall_release actual inst=%h pc4=%h v=%b pc=%h expected 8/c/1/c",
                     D_Inst, D_PC4, D_Valid, PC);
        end
        step();
        checks++;
        if (D_Inst !== 32'hC || PC !== 32'h10) begin
            errors++;
            $display("FAIL stall_resume actual inst=%h pc=%h expected c/10", D_Inst, PC);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        Pcsrc = 2'b10; Branch_addr = 32'h100;
        step();
        Pcsrc = 2'b00;
        checks++;
        if (Imem_addr !== 32'h100 || D_Valid !== 1'b0 || Flush !== 1'b1) begin
            errors++;
            $display("FAIL branch_redirect actual addr=%h v=%b fl=%b expected 100/0/1",
                     Imem_addr, D_Valid, Flush);
        end
        step();
        checks++;
        if (D_Inst !== 32'h100 || D_PC4 !== 32'h104 || D_Valid !== 1'b1 || Flush !== 1'b0) begin
            errors++;
            $display("FAIL branch_target actual inst=%h pc4=%h v=%b fl=%b expected 100/104/1/0",
                     D_Inst, D_PC4, D_Valid, Flush);
        end
    endtask

    task automatic test_kill();
        do_reset();
        step();
        Imem_ready = 1'b0; Pcsrc = 2'b10; Branch_addr = 32'h200;
        step();
        Pcsrc = 2'b00;
        checks++;
        if (Imem_addr !== 32'h4 || Imem_req !== 1'b1 || D_Valid !== 1'b0 || Flush !== 1'b1) begin
            errors++;
            $display("FAIL kill_enter actual addr=%h req=%b v=%b fl=%b expected 4/1/0/1",
                     Imem_addr, Imem_req, D_Valid, Flush);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (Imem_addr !== 32'h4 || D_Valid !== 1'b0 || Flush !== 1'b0) begin
                errors++;
                $display("FAIL kill_wait_%0d actual addr=%h v=%b fl=%b expected 4/0/0",
                         i, Imem_addr, D_Valid, Flush);
            end
        end
        Imem_ready = 1'b1;
        step();
        checks++;
        if (Imem_addr !== 32'h200 || D_Valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_drop actual addr=%h v=%b expected 200/0", Imem_addr, D_Valid);
        end
        step();
        checks++;
        if (D_Inst !== 32'h200 || D_Valid !== 1'b1 || PC !== 32'h204) begin
            errors++;
            $display("FAIL kill_target actual inst=%h v=%b pc=%h expected 200/1/204",
                     D_Inst, D_Valid, PC);
        end
    endtask

    task automatic test_jump_stall();
        do_reset();
        step(); step();
        Pcsrc = 2'b11; Jump_addr = 32'h40; stall = 1'b1;
        step();
        checks++;
        if (PC !== 32'h8 || D_Inst !== 32'h4) begin
            errors++;
            $display("FAIL jump_stalled actual pc=%h inst=%h expected 8/4", PC, D_Inst);
        end
        stall = 1'b0;
        step();
        Pcsrc = 2'b00;
        checks++;
        if (PC !== 32'h40 || D_Valid !== 1'b0 || Flush !== 1'b0) begin
            errors++;
            $display("FAIL jump_taken actual pc=%h v=%b fl=%b expected 40/0/0", PC, D_Valid, Flush);
        end
        step();
        checks++;
        if (D_Inst !== 32'h40 || D_Valid !== 1'b1 || PC !== 32'h44) begin
            errors++;
            $display("FAIL jump_target actual inst=%h v=%b pc=%h expected 40/1/44",
                     D_Inst, D_Valid, PC);
        end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        step(); step();
        Imem_ready = 1'b0;
        step();
        checks++;
        if (PC !== 32'h8 || D_Valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_bubble actual pc=%h v=%b expected 8/0", PC, D_Valid);
        end
        Rst = 1'b1; Imem_ready = 1'b1;
        step();
        checks++;
        if (PC !== 32'h0 || D_Valid !== 1'b0 || Imem_req !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset actual pc=%h v=%b req=%b expected 0/0/0",
                     PC, D_Valid, Imem_req);
        end
        Rst = 1'b0;
        step();
        checks++;
        if (D_Inst !== 32'h0 || D_PC4 !== 32'h4 || D_Valid !== 1'b1 || PC !== 32'h4) begin
            errors++;
            $display("FAIL midwait_first actual inst=%h pc4=%h v=%b pc=%h expected 0/4/1/4",
                     D_Inst, D_PC4, D_Valid, PC);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        Pcsrc = 2'b10; Branch_addr = 32'hFFFF_FFFC;
        step();
        Pcsrc = 2'b00;
        step();
        checks++;
        if (PC !== 32'h0 || D_Inst !== 32'hFFFF_FFFC || D_PC4 !== 32'h0 || D_Valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap actual pc=%h inst=%h pc4=%h v=%b expected 0/fffffffc/0/1",
                     PC, D_Inst, D_PC4, D_Valid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_kill();
        test_jump_stall();
        test_reset_midwait();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline; feeds Op/Func/Rs/Rt to the ID-stage control unit.
- Owns the PC and a valid/ready fetch interface to instruction memory.
- Applies the control unit's Pcsrc redirect (branch resolved in MEM, jump decoded in ID) and its load-use stall.
- Inserts NOP bubbles on wrong-path fetches and memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word used for bubbles; decodes as no write and no branch.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous active-high reset.
- Pcsrc  input  2  00/01 sequential, 10 taken branch (MEM stage), 11 jump (ID stage).
- Branch_addr  input  32  branch target from the MEM stage.
- Jump_addr  input  32  jump target formed in ID.
- stall  input  1  load-use stall from the control unit.
- Imem_req  output  1  fetch request.
- Imem_addr  output  32  fetch address; equals PC.
- Imem_ready  input  1  Imem_rdata valid for the current request.
- Imem_rdata  input  32  fetched word.
- PC  output  32  current fetch PC.
- D_Inst  output  32  IF/ID instruction.
- D_PC4  output  32  IF/ID PC+4.
- D_Valid  output  1  IF/ID holds a real instruction.
- Flush  output  1  registered; high for the one cycle after a taken branch is accepted, so ID/EX kills its entry.

Behaviour:
- Reset: one-cycle synchronous Rst sets PC=RESET_PC, D_Inst=NOP_INST, D_PC4=0, D_Valid=0, Flush=0, state=FETCH, skid buffer empty, Imem_req=0 during the reset cycle. Reset mid-fetch abandons the fetch; the first ready after reset belongs to the new request only.
- Memory protocol: Imem_req and Imem_addr stay stable from assertion until the cycle Imem_ready=1. A transfer completes on a cycle with Imem_req&Imem_ready. Zero-wait memory gives one instruction per cycle.
- Arithmetic: PC+4 wraps modulo 2^32. Targets are used as given; no alignment check.
- State FETCH:
  - req=1.
  - On completion with no redirect and no stall: D_Inst=rdata, D_PC4=PC+4, D_Valid=1, PC=PC+4.
  - Not ready, no stall: IF/ID loads a bubble (NOP_INST, D_Valid=0); PC holds.
- State HELD (entered when a fetch completes while stall=1):
  - Word captured in the skid buffer; req=0; PC holds; IF/ID holds.
  - When stall drops: buffer moves to IF/ID, PC=PC+4, go to FETCH.
- State KILL (entered when a redirect arrives while a fetch is outstanding and not completing):
  - Target latched in a redirect register; req stays high with the old address.
  - On ready: data discarded, PC=latched target, go to FETCH.
  - A later branch redirect overwrites the latched target.
  - IF/ID loads bubbles throughout.
- Priority, highest first:
  - Rst.
  - Branch (Pcsrc=10): PC or redirect register gets Branch_addr; IF/ID gets a bubble; skid buffer is cleared; Flush=1 next cycle. Overrides stall, because the older instruction kills younger ones.
  - stall: PC, IF/ID and buffer hold; a jump in ID is not taken while stalled.
  - Jump (Pcsrc=11): PC gets Jump_addr; IF/ID gets a bubble (wrong-path slot); no Flush.
  - Sequential.
- Redirect on the same cycle a fetch completes: the fetched word is discarded and PC is set to the target directly; KILL is not entered.
- Latency: a redirect target is on Imem_addr the cycle after Pcsrc is seen; its instruction reaches D_Inst one cycle after ready.

Decomposition:
- Shared package pipe_pkg: Pcsrc encodings (PCSRC_SEQ, PCSRC_BR=2'b10, PCSRC_J=2'b11), NOP_INST, RESET_PC default, if_state_t enum {FETCH, HELD, KILL}.
- No sub-module required. Optional sub-module pipe_ifid_reg: IF/ID register with hold/bubble controls.

Test Plan:
- Zero-wait memory returning word=addr: after reset, Imem_addr sequence is 0,4,8,C; D_Inst/D_PC4 = 0/4, 4/8, 8/C with D_Valid=1 each cycle.
- Pcsrc=10 with Branch_addr=0x100 at PC=0x10: next Imem_addr=0x100; D_Valid=0 for one cycle; Flush=1 for exactly one cycle; next valid D_PC4=0x104.
- stall for 2 cycles while fetching 0x8: PC holds at 0x8 and D_Inst holds for 2 cycles; then D_Inst=word(0x8), PC=0xC.
- Imem_ready low for 3 cycles at 0x4, branch to 0x200 in the first cycle: Imem_addr stays 0x4 until ready; that word never appears valid; then Imem_addr=0x200.
- Pcsrc=11 (Jump_addr=0x40) with stall=1: PC unchanged; after stall drops with Pcsrc=11, PC=0x40 and one bubble enters IF/ID.
- Rst asserted mid-wait at 0x8: next cycle PC=0, D_Valid=0, Imem_req=0; after release, the first completed word goes to address 0.
